// File: rtl/instr_issue_seq.sv
// Instruction sequencer: walks a small instruction store and issues each word to the
// R-type datapath under valid/ready, then samples tr_zf after RES_LAT cycles. Build macro: SEQ_LOOP_EN.
module instr_issue_seq #(
  parameter int          AW        = 4,
  parameter int          RES_LAT   = 2,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic          start,
  input  logic          instr_ready,
  input  logic          tr_zf,
  output logic [31:0]   instruccion_r,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic [AW:0]   zf_count,
  output logic          last_zf,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_READ, S_ISSUE, S_WAIT, S_DONE
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(RES_LAT - 1);

  state_t        r_state, w_next;
  logic [31:0]   r_mem [2**AW];
  logic [31:0]   r_rdata;
  logic [31:0]   r_instr;
  logic [AW-1:0] r_faddr;
  logic [AW-1:0] r_pc;
  logic [AW:0]   r_zf_count;
  logic          r_last_zf;
  logic [3:0]    r_lat_cnt;

  logic w_busy, w_start_run, w_accept, w_sample, w_halt, w_last_addr;

  assign w_busy      = (r_state == S_FETCH) || (r_state == S_READ) ||
                       (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign w_start_run = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_accept    = (r_state == S_ISSUE) && instr_ready;
  assign w_sample    = (r_state == S_WAIT) && (r_lat_cnt == '0);
  assign w_halt      = (r_rdata == HALT_WORD);
  assign w_last_addr = (r_faddr == {AW{1'b1}});

  // NOTE: the store has no reset; contents survive rst and need no reset fan-out.
  always_ff @(posedge clk) begin
    if (load_en && !w_busy)
      r_mem[load_addr] <= load_data;
    r_rdata <= r_mem[r_faddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_FETCH;
      S_FETCH:        w_next = S_READ;
      S_READ:         w_next = w_halt ? S_DONE : S_ISSUE;
      S_ISSUE:        if (instr_ready) w_next = S_WAIT;
      S_WAIT: begin
        if (w_sample) begin
`ifdef SEQ_LOOP_EN
          w_next = S_FETCH;
`else
          w_next = w_last_addr ? S_DONE : S_FETCH;
`endif
        end
      end
      default:        w_next = S_IDLE;
    endcase
  end

  // r_faddr walks the store; r_pc only takes a new address once that word is issued,
  // so a HALT fetch leaves pc on the last-issued instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_faddr    <= '0;
      r_pc       <= '0;
      r_instr    <= '0;
      r_zf_count <= '0;
      r_last_zf  <= 1'b0;
      r_lat_cnt  <= '0;
    end else begin
      if (w_start_run) begin
        r_faddr    <= '0;
        r_pc       <= '0;
        r_zf_count <= '0;
        r_last_zf  <= 1'b0;
      end
      if ((r_state == S_READ) && !w_halt) begin
        r_instr <= r_rdata;
        r_pc    <= r_faddr;
      end
      if (w_accept)
        r_lat_cnt <= LAT_INIT;
      else if ((r_state == S_WAIT) && (r_lat_cnt != '0))
        r_lat_cnt <= r_lat_cnt - 4'd1;
      if (w_sample) begin
        r_last_zf <= tr_zf;
        if (tr_zf && (r_zf_count != {(AW+1){1'b1}}))
          r_zf_count <= r_zf_count + 1'b1;
`ifdef SEQ_LOOP_EN
        r_faddr <= r_faddr + 1'b1;
`else
        if (!w_last_addr)
          r_faddr <= r_faddr + 1'b1;
`endif
      end
    end
  end

  assign instruccion_r = r_instr;
  assign instr_valid   = (r_state == S_ISSUE);
  assign pc            = r_pc;
  assign zf_count      = r_zf_count;
  assign last_zf       = r_last_zf;
  assign busy          = w_busy;
  assign done          = (r_state == S_DONE);

endmodule

// File: tb/tb_instr_issue_seq.sv
// Directed bench for instr_issue_seq: handshake ordering, stall hold, HALT handling,
// full-store run, async reset mid-issue and load protection while busy.
module tb_instr_issue_seq;

  localparam int AW = 4;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic          start;
  logic          instr_ready;
  logic          tr_zf;
  logic [31:0]   instruccion_r;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic [AW:0]   zf_count;
  logic          last_zf;
  logic          busy;
  logic          done;

  int n_assert = 0;
  int n_fail   = 0;
  int n_hs     = 0;
  int hs_base  = 0;
  logic zf_all = 1'b0;
  logic [31:0] hs_q[$];

  instr_issue_seq #(.AW(AW), .RES_LAT(2), .HALT_WORD(HALT)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .instr_ready(instr_ready),
    .tr_zf(tr_zf), .instruccion_r(instruccion_r), .instr_valid(instr_valid),
    .pc(pc), .zf_count(zf_count), .last_zf(last_zf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // tr_zf is 1 everywhere when zf_all, otherwise only after the 2nd handshake of a run.
  always_comb tr_zf = zf_all | ((n_hs - hs_base) == 2);

  always @(negedge clk) begin
    if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
      hs_q.push_back(instruccion_r);
      n_hs = n_hs + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic pulse_start();
    hs_base = n_hs;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (done !== 1'b1 && i < budget) begin tick(); i++; end
    check("done_reached", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_hs(input int target, input int budget);
    int i = 0;
    while ((n_hs - hs_base) < target && i < budget) begin tick(); i++; end
    check("hs_reached", 32'(n_hs - hs_base >= target), 32'd1);
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; instr_ready = 1'b1;
    #3;
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instruccion_r, 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_zf_count", 32'(zf_count), 32'd0);
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check("rst_last_zf", {31'd0, last_zf}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Two-instruction program, ready tied high
    load(4'd0, 32'h00A10000);
    load(4'd1, 32'h00C45000);
    load(4'd2, HALT);
    pulse_start();
    check("t1_lat1_valid", {31'd0, instr_valid}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    tick();
    check("t1_lat2_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    check("t1_first_valid", {31'd0, instr_valid}, 32'd1);
    check("t1_first_word", instruccion_r, 32'h00A10000);
    wait_done(60);
    check("t1_issues", 32'(n_hs - hs_base), 32'd2);
    check("t1_word0", hs_q[hs_base], 32'h00A10000);
    check("t1_word1", hs_q[hs_base+1], 32'h00C45000);
    check("t1_zf_count", 32'(zf_count), 32'd1);
    check("t1_last_zf", {31'd0, last_zf}, 32'd1);
    check("t1_pc", 32'(pc), 32'd1);
    check("t1_busy_off", {31'd0, busy}, 32'd0);

    // Same program, first issue stalled for 5 cycles
    instr_ready = 1'b0;
    pulse_start();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t2_stall_valid", {31'd0, instr_valid}, 32'd1);
      check("t2_stall_word", instruccion_r, 32'h00A10000);
      tick();
    end
    check("t2_no_early_hs", 32'(n_hs - hs_base), 32'd0);
    instr_ready = 1'b1;
    tick();
    check("t2_accepted", {31'd0, instr_valid}, 32'd0);
    check("t2_one_hs", 32'(n_hs - hs_base), 32'd1);
    wait_done(60);
    check("t2_issues", 32'(n_hs - hs_base), 32'd2);
    check("t2_zf_count", 32'(zf_count), 32'd1);

    // HALT at address 0: no issue at all
    load(4'd0, HALT);
    pulse_start();
    tick();
    check("t3_not_yet_done", {31'd0, done}, 32'd0);
    tick();
    check("t3_done", {31'd0, done}, 32'd1);
    check("t3_issues", 32'(n_hs - hs_base), 32'd0);
    check("t3_zf_count", 32'(zf_count), 32'd0);
    check("t3_pc", 32'(pc), 32'd0);

    // Full store, tr_zf constantly high
    for (int i = 0; i < 16; i++) load(4'(i), 32'hA000_0000 | 32'(i));
    zf_all = 1'b1;
    pulse_start();
`ifdef SEQ_LOOP_EN
    wait_hs(17, 300);
    check("t4_wrap_word", hs_q[hs_base+16], 32'hA000_0000);
    check("t4_wrap_pc", 32'(pc), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
`else
    wait_hs(16, 200);
    wait_done(40);
    check("t4_issues", 32'(n_hs - hs_base), 32'd16);
    check("t4_zf_count", 32'(zf_count), 32'd16);
    check("t4_pc", 32'(pc), 32'd15);
    check("t4_last_word", hs_q[hs_base+15], 32'hA000_000F);
`endif

    // Stall in ISSUE, attempt a load while busy, then async reset
    instr_ready = 1'b0;
    pulse_start();
    tick();
    tick();
    check("t5_issue_valid", {31'd0, instr_valid}, 32'd1);
    load(4'd3, 32'h12345678);
    check("t5_still_busy", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_valid", {31'd0, instr_valid}, 32'd0);
    check("t5_rst_instr", instruccion_r, 32'd0);
    check("t5_rst_pc_zf", {pc, zf_count, last_zf}, 32'd0);
    check("t5_rst_busy_done", {30'd0, busy, done}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    instr_ready = 1'b1;
    pulse_start();
    wait_hs(16, 200);
    check("t5_restart_word0", hs_q[hs_base], 32'hA000_0000);
    check("t5_word3_intact", hs_q[hs_base+3], 32'hA000_0003);
`ifndef SEQ_LOOP_EN
    wait_done(40);
    check("t5_pc", 32'(pc), 32'd15);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
